core_id_stage_pipe: RTL and testbench

Parametrised decode stage with a registered ID/EX output slot and valid/ready handshakes on both sides. It decodes the instruction, reads a configurable RV32I/RV32E register file with write-back bypass, and flags illegal instructions. It inserts load-use bubbles of configurable length and supports flush. It sits between the fetch stage and the execute stage.

---
 rtl/core_pkg.sv | 30 +++
 rtl/core_regfile_bypass.sv | 49 ++++
 rtl/core_id_stage_pipe.sv | 179 +++++++++++++++++
 tb/tb_core_id_stage_pipe.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// core_pkg: RV32 opcode constants and the decoded ID/EX control slot shared by the decode stage.
package core_pkg;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [2:0] funct3;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [6:0] funct7;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       illegal;
   } id_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/core_regfile_bypass.sv
`default_nettype none
// core_regfile_bypass: NREGS x XLEN register file, two read ports, one write port,
// x0 hardwired to zero and same-cycle write-first bypass.
module core_regfile_bypass #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   localparam int         IW      = $clog2(NREGS);
   localparam logic [5:0] NREGS_L = 6'(NREGS);

   logic [XLEN-1:0] mem [NREGS];
   logic            wr_ok;

   assign wr_ok = we && (waddr != 5'd0) && ({1'b0, waddr} < NREGS_L);

   // Indices beyond the implemented file read as zero, like x0.
   always_comb begin
      rdata1 = '0;
      if (raddr1 != 5'd0 && {1'b0, raddr1} < NREGS_L)
         rdata1 = (wr_ok && waddr == raddr1) ? wdata : mem[raddr1[IW-1:0]];
   end

   always_comb begin
      rdata2 = '0;
      if (raddr2 != 5'd0 && {1'b0, raddr2} < NREGS_L)
         rdata2 = (wr_ok && waddr == raddr2) ? wdata : mem[raddr2[IW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (wr_ok) begin
         mem[waddr[IW-1:0]] <= wdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/core_id_stage_pipe.sv
`default_nettype none
// core_id_stage_pipe: decode stage with registered ID/EX slot, valid/ready handshakes,
// load-use bubble insertion, flush, write-back bypass and illegal-instruction flagging.
module core_id_stage_pipe
   import core_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int NREGS          = 32,
   parameter int LOAD_USE_STALL = 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [XLEN-1:0] i_instr,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_flush,
   input  logic            i_wb_reg_write,
   input  logic [4:0]      i_wb_rd,
   input  logic [XLEN-1:0] i_rd_din,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_imm,
   output logic [XLEN-1:0] o_rs1_dout,
   output logic [XLEN-1:0] o_rs2_dout,
   output logic [6:0]      o_opcode,
   output logic [4:0]      o_rd,
   output logic [2:0]      o_funct3,
   output logic [4:0]      o_rs1,
   output logic [4:0]      o_rs2,
   output logic [6:0]      o_funct7,
   output logic            o_mem_read,
   output logic            o_mem_write,
   output logic            o_reg_write,
   output logic            o_illegal
);

   localparam logic [5:0] NREGS_L = 6'(NREGS);

   logic [31:0]     instr;
   id_ctrl_t        dec, ctrl_q;
   logic            use_rs1, use_rs2, use_rd, known;
   logic [31:0]     imm32;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic [1:0]      stall_cnt;
   logic [4:0]      load_rd;
   logic            advance, hazard_slot, hazard_cnt, transfer, load_leave, wb_ok;

   assign instr = i_instr[31:0];

   always_comb begin
      dec        = '0;
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      use_rd     = 1'b0;
      known      = 1'b1;
      imm32      = '0;
      dec.opcode = instr[6:0];
      dec.rd     = instr[11:7];
      dec.funct3 = instr[14:12];
      dec.rs1    = instr[19:15];
      dec.rs2    = instr[24:20];
      dec.funct7 = instr[31:25];
      case (instr[6:0])
         OP: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
         end
         OP_IMM, JALR, SYSTEM: begin
            use_rs1 = 1'b1; use_rd = 1'b1;
            imm32   = {{20{instr[31]}}, instr[31:20]};
         end
         LOAD: begin
            use_rs1      = 1'b1; use_rd = 1'b1;
            dec.mem_read = 1'b1;
            imm32        = {{20{instr[31]}}, instr[31:20]};
         end
         STORE: begin
            use_rs1       = 1'b1; use_rs2 = 1'b1;
            dec.mem_write = 1'b1;
            imm32         = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         BRANCH: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         JAL: begin
            use_rd = 1'b1;
            imm32  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         LUI, AUIPC: begin
            use_rd = 1'b1;
            imm32  = {instr[31:12], 12'b0};
         end
         default: known = 1'b0;
      endcase
      // RV32E has no x16..x31: any used register index with bit 4 set is illegal.
      dec.illegal   = !known || (NREGS == 16 &&
                      ((use_rs1 && instr[19]) || (use_rs2 && instr[24]) || (use_rd && instr[11])));
      dec.reg_write = use_rd && !dec.illegal;
      if (dec.illegal) begin
         dec.mem_read  = 1'b0;
         dec.mem_write = 1'b0;
      end
   end

   core_regfile_bypass #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .we     (i_wb_reg_write),
      .waddr  (i_wb_rd),
      .wdata  (i_rd_din),
      .raddr1 (dec.rs1),
      .raddr2 (dec.rs2),
      .rdata1 (rs1_data),
      .rdata2 (rs2_data)
   );

   assign wb_ok       = i_wb_reg_write && (i_wb_rd != 5'd0) && ({1'b0, i_wb_rd} < NREGS_L);
   assign advance     = !o_valid || i_ready;
   assign hazard_slot = o_valid && o_mem_read && (o_rd != 5'd0) &&
                        ((use_rs1 && dec.rs1 == o_rd) || (use_rs2 && dec.rs2 == o_rd));
   assign hazard_cnt  = (stall_cnt != 2'd0) &&
                        ((use_rs1 && dec.rs1 != 5'd0 && dec.rs1 == load_rd) ||
                         (use_rs2 && dec.rs2 != 5'd0 && dec.rs2 == load_rd));
   assign o_ready     = advance && !i_flush && !hazard_slot && !hazard_cnt;
   assign transfer    = i_valid && o_ready;
   assign load_leave  = o_valid && i_ready && o_mem_read && (o_rd != 5'd0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid    <= 1'b0;
         ctrl_q     <= '0;
         o_pc       <= '0;
         o_imm      <= '0;
         o_rs1_dout <= '0;
         o_rs2_dout <= '0;
         stall_cnt  <= '0;
         load_rd    <= '0;
      end else if (i_flush) begin
         o_valid   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         if (transfer) begin
            o_valid    <= 1'b1;
            ctrl_q     <= dec;
            o_pc       <= i_pc;
            o_imm      <= XLEN'($signed(imm32));
            o_rs1_dout <= rs1_data;
            o_rs2_dout <= rs2_data;
         end else if (advance) begin
            o_valid <= 1'b0;
         end else begin
            // Held slot snoops write-back so operands stay current while stalled downstream.
            if (wb_ok && i_wb_rd == ctrl_q.rs1) o_rs1_dout <= i_rd_din;
            if (wb_ok && i_wb_rd == ctrl_q.rs2) o_rs2_dout <= i_rd_din;
         end
         if (load_leave) begin
            load_rd   <= o_rd;
            stall_cnt <= 2'(LOAD_USE_STALL - 1);
         end else if (advance && stall_cnt != 2'd0) begin
            stall_cnt <= stall_cnt - 2'd1;
         end
      end
   end

   assign o_opcode    = ctrl_q.opcode;
   assign o_rd        = ctrl_q.rd;
   assign o_funct3    = ctrl_q.funct3;
   assign o_rs1       = ctrl_q.rs1;
   assign o_rs2       = ctrl_q.rs2;
   assign o_funct7    = ctrl_q.funct7;
   assign o_mem_read  = ctrl_q.mem_read;
   assign o_mem_write = ctrl_q.mem_write;
   assign o_reg_write = ctrl_q.reg_write;
   assign o_illegal   = ctrl_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_core_id_stage_pipe.sv
`default_nettype none
// tb_core_id_stage_pipe: drives an RV32I (stall 1) and an RV32E (stall 3) instance with shared
// stimulus and checks both against a behavioural model of the decode stage.
module tb_core_id_stage_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        valid, flush, wbw, rdy;
   logic [31:0] instr, pc, wbd;
   logic [4:0]  wbrd;

   logic        ordy [2], ovld [2], omr [2], omw [2], orw [2], oill [2];
   logic [31:0] opc [2], oimm [2], od1 [2], od2 [2];
   logic [6:0]  oop [2], of7 [2];
   logic [4:0]  ord [2], ors1 [2], ors2 [2];
   logic [2:0]  of3 [2];

   core_id_stage_pipe #(.XLEN(32), .NREGS(32), .LOAD_USE_STALL(1)) dut_i (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ordy[0]), .i_instr(instr),
      .i_pc(pc), .i_flush(flush), .i_wb_reg_write(wbw), .i_wb_rd(wbrd), .i_rd_din(wbd),
      .o_valid(ovld[0]), .i_ready(rdy), .o_pc(opc[0]), .o_imm(oimm[0]), .o_rs1_dout(od1[0]),
      .o_rs2_dout(od2[0]), .o_opcode(oop[0]), .o_rd(ord[0]), .o_funct3(of3[0]), .o_rs1(ors1[0]),
      .o_rs2(ors2[0]), .o_funct7(of7[0]), .o_mem_read(omr[0]), .o_mem_write(omw[0]),
      .o_reg_write(orw[0]), .o_illegal(oill[0]));

   core_id_stage_pipe #(.XLEN(32), .NREGS(16), .LOAD_USE_STALL(3)) dut_e (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ordy[1]), .i_instr(instr),
      .i_pc(pc), .i_flush(flush), .i_wb_reg_write(wbw), .i_wb_rd(wbrd), .i_rd_din(wbd),
      .o_valid(ovld[1]), .i_ready(rdy), .o_pc(opc[1]), .o_imm(oimm[1]), .o_rs1_dout(od1[1]),
      .o_rs2_dout(od2[1]), .o_opcode(oop[1]), .o_rd(ord[1]), .o_funct3(of3[1]), .o_rs1(ors1[1]),
      .o_rs2(ors2[1]), .o_funct7(of7[1]), .o_mem_read(omr[1]), .o_mem_write(omw[1]),
      .o_reg_write(orw[1]), .o_illegal(oill[1]));

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   typedef struct packed {
      logic        v;
      logic [31:0] pc, imm, d1, d2;
      logic [6:0]  op, f7;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic        mr, mw, rw, ill, u1, u2;
   } slot_t;

   slot_t       ms [2];
   logic [31:0] mregs [2][32];
   logic [4:0]  lrd [2];
   int          since [2];   // advance cycles since the last load left the slot
   logic        rdy_seen [2];

   function automatic int nregs_of(input int k);
      return (k == 0) ? 32 : 16;
   endfunction

   function automatic int stall_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic slot_t decode(input logic [31:0] ins, input int nr);
      slot_t s;
      int    si;
      logic  urd, known;
      s = '0; urd = 1'b0; known = 1'b1;
      si = int'(ins);
      s.op = ins[6:0]; s.rd = ins[11:7]; s.f3 = ins[14:12];
      s.rs1 = ins[19:15]; s.rs2 = ins[24:20]; s.f7 = ins[31:25];
      case (s.op)
         7'h33: begin s.u1 = 1; s.u2 = 1; urd = 1; end
         7'h13, 7'h67, 7'h73: begin s.u1 = 1; urd = 1; s.imm = 32'(si >>> 20); end
         7'h03: begin s.u1 = 1; urd = 1; s.mr = 1; s.imm = 32'(si >>> 20); end
         7'h23: begin
            s.u1 = 1; s.u2 = 1; s.mw = 1;
            s.imm = 32'((si >>> 25) << 5) | ((ins >> 7) & 32'h1f);
         end
         7'h63: begin
            s.u1 = 1; s.u2 = 1;
            s.imm = 32'((si >>> 31) << 12) | (((ins >> 7) & 32'h1) << 11) |
                    (((ins >> 25) & 32'h3f) << 5) | (((ins >> 8) & 32'hf) << 1);
         end
         7'h6f: begin
            urd = 1;
            s.imm = 32'((si >>> 31) << 20) | (ins & 32'h000ff000) |
                    (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3ff) << 1);
         end
         7'h37, 7'h17: begin urd = 1; s.imm = ins & 32'hfffff000; end
         default: known = 1'b0;
      endcase
      s.ill = !known || (nr == 16 && ((s.u1 && s.rs1 >= 16) || (s.u2 && s.rs2 >= 16) ||
                                      (urd && s.rd >= 16)));
      s.rw = urd && !s.ill;
      if (s.ill) begin s.mr = 0; s.mw = 0; end
      return s;
   endfunction

   function automatic logic wb_hits(input int k, input logic [4:0] a);
      return wbw && wbrd != 0 && int'(wbrd) < nregs_of(k) && wbrd == a;
   endfunction

   function automatic logic [31:0] mread(input int k, input logic [4:0] a);
      if (a == 0 || int'(a) >= nregs_of(k)) return 32'h0;
      if (wb_hits(k, a)) return wbd;
      return mregs[k][a];
   endfunction

   function automatic logic m_ready(input int k);
      slot_t s;
      logic  h;
      s = decode(instr, nregs_of(k));
      h = (ms[k].v && ms[k].mr && ms[k].rd != 0 &&
           ((s.u1 && s.rs1 == ms[k].rd) || (s.u2 && s.rs2 == ms[k].rd))) ||
          (since[k] < stall_of(k) - 1 &&
           ((s.u1 && s.rs1 != 0 && s.rs1 == lrd[k]) || (s.u2 && s.rs2 != 0 && s.rs2 == lrd[k])));
      return (!ms[k].v || rdy) && !flush && !h;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         ms[k] = '0; lrd[k] = '0; since[k] = 100;
         for (int r = 0; r < 32; r++) mregs[k][r] = '0;
      end
   endtask

   task automatic model_update(input int k);
      slot_t n;
      logic  adv, xfer, leave;
      adv   = !ms[k].v || rdy;
      xfer  = valid && m_ready(k);
      leave = ms[k].v && rdy && ms[k].mr && ms[k].rd != 0;
      if (flush) begin
         ms[k].v = 0; since[k] = 100;
      end else begin
         if (leave) begin lrd[k] = ms[k].rd; since[k] = 0; end
         else if (adv && since[k] < 100) since[k]++;
         if (xfer) begin
            n = decode(instr, nregs_of(k));
            n.v = 1; n.pc = pc;
            n.d1 = mread(k, n.rs1); n.d2 = mread(k, n.rs2);
            ms[k] = n;
         end else if (adv) begin
            ms[k].v = 0;
         end else begin
            if (wb_hits(k, ms[k].rs1)) ms[k].d1 = wbd;
            if (wb_hits(k, ms[k].rs2)) ms[k].d2 = wbd;
         end
      end
      if (wbw && wbrd != 0 && int'(wbrd) < nregs_of(k)) mregs[k][wbrd] = wbd;
   endtask

   // Called at a negedge with inputs already applied; returns at the next negedge.
   task automatic step();
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("valid%0d", k), 32'(ovld[k]), 32'(ms[k].v));
         check($sformatf("ready%0d", k), 32'(ordy[k]), 32'(m_ready(k)));
         rdy_seen[k] = ordy[k];
         if (ms[k].v) begin
            check($sformatf("pc%0d", k), opc[k], ms[k].pc);
            check($sformatf("imm%0d", k), oimm[k], ms[k].imm);
            check($sformatf("rs1d%0d", k), od1[k], ms[k].d1);
            check($sformatf("rs2d%0d", k), od2[k], ms[k].d2);
            check($sformatf("fields%0d", k), {oop[k], ord[k], of3[k], ors1[k], ors2[k], of7[k]},
                  {ms[k].op, ms[k].rd, ms[k].f3, ms[k].rs1, ms[k].rs2, ms[k].f7});
            check($sformatf("ctrl%0d", k), 32'({omr[k], omw[k], orw[k], oill[k]}),
                  32'({ms[k].mr, ms[k].mw, ms[k].rw, ms[k].ill}));
         end
      end
      for (int k = 0; k < 2; k++) model_update(k);
      @(negedge clk);
   endtask

   task automatic random_inputs();
      logic [6:0] ops [12];
      ops = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73, 7'h7f};
      valid = ($urandom_range(0, 9) < 8);
      rdy   = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      wbw   = 1'($urandom_range(0, 1));
      wbrd  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      wbd   = $urandom;
      pc    = pc + 32'd4;
      instr = $urandom;
      instr[6:0] = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 15) != 0) begin
         instr[11:7]  = 5'($urandom_range(0, 6));
         instr[19:15] = 5'($urandom_range(0, 6));
         instr[24:20] = 5'($urandom_range(0, 6));
      end
   endtask

   int stalls [2];
   logic done [2];

   initial begin
      valid = 0; flush = 0; wbw = 0; rdy = 1; instr = 0; pc = 0; wbd = 0; wbrd = 0;
      model_reset();
      @(negedge clk); @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_valid%0d", k), 32'(ovld[k]), 0);
         check($sformatf("rst_pc%0d", k), opc[k], 0);
         check($sformatf("rst_imm%0d", k), oimm[k], 0);
         check($sformatf("rst_ctrl%0d", k), 32'({omr[k], omw[k], orw[k], oill[k]}), 0);
         check($sformatf("rst_ready%0d", k), 32'(ordy[k]), 1);
      end
      @(negedge clk);
      rst_n = 1;

      // ADDI x1,x0,5
      instr = 32'h00500093; valid = 1; pc = 32'h100; step();
      valid = 0;
      check("addi_valid", 32'(ovld[0]), 1);
      check("addi_rd", 32'(ord[0]), 1);
      check("addi_imm", oimm[0], 5);
      check("addi_rw", 32'(orw[0]), 1);
      step();

      // LW x2,0(x1) then dependent ADD x3,x2,x2
      instr = 32'h0000a103; valid = 1; pc = 32'h104; step();
      instr = 32'h002101b3; pc = 32'h108;
      stalls[0] = 0; stalls[1] = 0; done[0] = 0; done[1] = 0;
      for (int c = 0; c < 8 && !(done[0] && done[1]); c++) begin
         step();
         for (int k = 0; k < 2; k++)
            if (!done[k]) begin
               if (rdy_seen[k]) done[k] = 1;
               else stalls[k]++;
            end
      end
      for (int k = 0; k < 2; k++)
         check($sformatf("load_use_bubbles%0d", k), stalls[k], stall_of(k));
      valid = 0; step(); step();

      // ADD x5,x4,x0 with x4 written back in the same cycle
      instr = 32'h000202b3; valid = 1; wbw = 1; wbrd = 4; wbd = 32'hdead; step();
      valid = 0; wbw = 0;
      for (int k = 0; k < 2; k++) check($sformatf("bypass_rs1%0d", k), od1[k], 32'hdead);
      step();

      // ADD x7,x0,x6 held downstream while x6 is written back
      instr = 32'h006003b3; valid = 1; rdy = 1; step();
      valid = 0; rdy = 0; wbw = 1; wbrd = 6; wbd = 32'h1234; step();
      wbw = 0; step();
      for (int k = 0; k < 2; k++) check($sformatf("snoop_rs2%0d", k), od2[k], 32'h1234);

      // Flush while the slot is held and fetch presents an instruction
      instr = 32'h00500093; valid = 1; flush = 1; step();
      flush = 0; valid = 0; rdy = 1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("flush_ready%0d", k), 32'(rdy_seen[k]), 0);
         check($sformatf("flush_valid%0d", k), 32'(ovld[k]), 0);
      end

      // ADD x17,x1,x2: legal on RV32I, illegal on RV32E
      instr = 32'h002088b3; valid = 1; step();
      check("rv32e_ill", 32'(oill[1]), 1);
      check("rv32e_rw", 32'(orw[1]), 0);
      check("rv32i_ill", 32'(oill[0]), 0);
      check("rv32i_rw", 32'(orw[0]), 1);
      instr = 32'h0000007f; step();
      valid = 0;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("bad_op_ill%0d", k), 32'(oill[k]), 1);
         check($sformatf("bad_op_rw%0d", k), 32'(orw[k]), 0);
      end
      step();

      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            rst_n = 0; valid = 0; flush = 0; wbw = 0;
            #1;
            for (int k = 0; k < 2; k++) check($sformatf("async_rst%0d", k), 32'(ovld[k]), 0);
            model_reset();
            @(negedge clk);
            rst_n = 1;
         end
         random_inputs();
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
